// File: rtl/ram_responder.sv
// ram_responder
// Memory-side end of the burst RAM bus. It serves one write or one read burst
// at a time from an internal word array, with every bus output registered.
// The word index comes from byte address bits [DEPTH_LOG2+1:2] and wraps at
// the top of the array, so there is no out-of-range error response.
// Reset clears the control state and outputs but never the array contents.

module ram_responder #(
    parameter int AWIDTH     = 32,
    parameter int LWIDTH     = 8,
    parameter int DWIDTH     = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] awaddr,
    input  logic [LWIDTH-1:0] awlen,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DWIDTH-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    output logic              wlast,
    input  logic [AWIDTH-1:0] araddr,
    input  logic [LWIDTH-1:0] arlen,
    input  logic              arvalid,
    output logic              arready,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    input  logic              rready,
    output logic              rlast
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_BEAT  = 2'd1;
    localparam logic [1:0] RD_FETCH = 2'd2;
    localparam logic [1:0] RD_DATA  = 2'd3;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [LWIDTH-1:0]     cnt_q, cnt_d;
    logic [LWIDTH-1:0]     len_q, len_d;

    logic awready_q, awready_d;
    logic arready_q, arready_d;
    logic wvalid_q,  wvalid_d;
    logic wlast_q,   wlast_d;
    logic rvalid_q,  rvalid_d;
    logic rlast_q,   rlast_d;
    logic [DWIDTH-1:0] rdata_q;

    logic [DWIDTH-1:0] mem [0:DEPTH-1];

    logic                  wrAccept;
    logic                  rdAccept;
    logic                  wrBeat;
    logic                  rdBeat;
    logic                  rdFetch;
    logic [DEPTH_LOG2-1:0] idxInc;
    logic [LWIDTH-1:0]     cntInc;
    logic [DEPTH_LOG2-1:0] awIdx;
    logic [DEPTH_LOG2-1:0] arIdx;
    logic                  unusedAddrBits;

    // awready/arready are only ever high while idle, so they double as the
    // "may accept" qualifier; a write always wins over a simultaneous read.
    assign wrAccept = awready_q && awvalid;
    assign rdAccept = arready_q && arvalid && !awvalid;
    assign wrBeat   = (state_q == WR_BEAT) && wvalid_q && wready;
    assign rdBeat   = (state_q == RD_DATA) && rvalid_q && rready;
    assign rdFetch  = (state_q == RD_FETCH);

    assign idxInc = idx_q + DEPTH_LOG2'(1);
    assign cntInc = cnt_q + LWIDTH'(1);
    assign awIdx  = awaddr[DEPTH_LOG2+1:2];
    assign arIdx  = araddr[DEPTH_LOG2+1:2];

    assign unusedAddrBits = ^{awaddr[AWIDTH-1:DEPTH_LOG2+2], awaddr[1:0],
                              araddr[AWIDTH-1:DEPTH_LOG2+2], araddr[1:0]};

    assign awready = awready_q;
    assign arready = arready_q;
    assign wvalid  = wvalid_q;
    assign wlast   = wlast_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rdata   = rdata_q;

    // Next-state logic: burst sequencing plus the registered output values for the coming cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        wvalid_d = wvalid_q;
        wlast_d  = wlast_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;

        case (state_q)
            IDLE: begin
                if (wrAccept) begin
                    state_d  = WR_BEAT;
                    idx_d    = awIdx;
                    len_d    = awlen;
                    cnt_d    = '0;
                    wvalid_d = 1'b1;
                    wlast_d  = (awlen == '0);
                end else if (rdAccept) begin
                    state_d = RD_FETCH;
                    idx_d   = arIdx;
                    len_d   = arlen;
                    cnt_d   = '0;
                end
            end

            WR_BEAT: begin
                if (wrBeat) begin
                    idx_d = idxInc;
                    cnt_d = cntInc;
                    if (wlast_q) begin
                        state_d  = IDLE;
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                    end else begin
                        wlast_d = (cntInc == len_q);
                    end
                end
            end

            RD_FETCH: begin
                state_d  = RD_DATA;
                rvalid_d = 1'b1;
                rlast_d  = (cnt_q == len_q);
            end

            RD_DATA: begin
                if (rdBeat) begin
                    idx_d    = idxInc;
                    cnt_d    = cntInc;
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    state_d  = rlast_q ? IDLE : RD_FETCH;
                end
            end

            default: begin
                state_d  = IDLE;
                wvalid_d = 1'b0;
                wlast_d  = 1'b0;
                rvalid_d = 1'b0;
                rlast_d  = 1'b0;
            end
        endcase

        awready_d = (state_d == IDLE);
        arready_d = (state_d == IDLE);
    end

    // Control and handshake registers, synchronously cleared by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    // Read data register: loaded once per beat in the fetch cycle and held until the beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rdFetch) begin
            rdata_q <= mem[idx_q];
        end
    end

    // Word array write port; it has no reset, and a write is suppressed in a reset cycle so an aborted beat leaves the old word.
    always_ff @(posedge clk) begin
        if (wrBeat && !rst) begin
            mem[idx_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder
// Directed bench for ram_responder. A table of single-beat write/read vectors
// is followed by hand-written multi-cycle sequences: wready throttling,
// rready stalls, simultaneous requests, index wrap, and reset mid-burst.

module tb_ram_responder;

    localparam int AW = 32;
    localparam int LW = 8;
    localparam int DW = 32;
    localparam int DL = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] awaddr;
    logic [LW-1:0] awlen;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic          wlast;
    logic [AW-1:0] araddr;
    logic [LW-1:0] arlen;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          rlast;

    int checks = 0;
    int errors = 0;

    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [5];

    ram_responder #(
        .AWIDTH(AW),
        .LWIDTH(LW),
        .DWIDTH(DW),
        .DEPTH_LOG2(DL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .awaddr(awaddr),
        .awlen(awlen),
        .awvalid(awvalid),
        .awready(awready),
        .wdata(wdata),
        .wvalid(wvalid),
        .wready(wready),
        .wlast(wlast),
        .araddr(araddr),
        .arlen(arlen),
        .arvalid(arvalid),
        .arready(arready),
        .rdata(rdata),
        .rvalid(rvalid),
        .rready(rready),
        .rlast(rlast)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Global time limit so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'b0, actual}, {31'b0, expected});
    endtask

    task automatic checkAllZero(input string name);
        checkBit({name, "_awready"}, awready, 1'b0);
        checkBit({name, "_arready"}, arready, 1'b0);
        checkBit({name, "_wvalid"}, wvalid, 1'b0);
        checkBit({name, "_wlast"}, wlast, 1'b0);
        checkBit({name, "_rvalid"}, rvalid, 1'b0);
        checkBit({name, "_rlast"}, rlast, 1'b0);
        checkOutput({name, "_rdata"}, rdata, 32'h0);
    endtask

    task automatic writeBurst(input logic [31:0] addr, input int len, input bit toggle);
        int w;
        int beat;
        int cyc;
        awaddr  = addr;
        awlen   = 8'(len);
        awvalid = 1'b1;
        w = 0;
        while (!awready && w < 20) begin
            step();
            w++;
        end
        checkBit("aw_accept", awready, 1'b1);
        step();
        awvalid = 1'b0;
        checkBit("wvalid_first", wvalid, 1'b1);
        checkBit("arready_busy", arready, 1'b0);
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 64) begin
            wdata  = wbuf[beat];
            wready = toggle ? (cyc % 2 == 0) : 1'b1;
            checkBit("wvalid_beat", wvalid, 1'b1);
            checkBit("wlast_beat", wlast, beat == len);
            step();
            if (wready) beat++;
            cyc++;
        end
        wready = 1'b0;
        checkBit("wvalid_done", wvalid, 1'b0);
        checkBit("wlast_done", wlast, 1'b0);
        checkBit("awready_back", awready, 1'b1);
    endtask

    task automatic readBurst(input logic [31:0] addr, input int len, input int stallBeat, output int waits);
        araddr  = addr;
        arlen   = 8'(len);
        arvalid = 1'b1;
        waits = 0;
        while (!arready && waits < 40) begin
            step();
            waits++;
        end
        checkBit("ar_accept", arready, 1'b1);
        step();
        arvalid = 1'b0;
        checkBit("rvalid_fetch", rvalid, 1'b0);
        for (int beat = 0; beat <= len; beat++) begin
            step();
            checkBit("rvalid_beat", rvalid, 1'b1);
            checkOutput("rdata_beat", rdata, rbuf[beat]);
            checkBit("rlast_beat", rlast, beat == len);
            if (beat == stallBeat) begin
                rready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    checkBit("rvalid_stall", rvalid, 1'b1);
                    checkOutput("rdata_stall", rdata, rbuf[beat]);
                    checkBit("rlast_stall", rlast, beat == len);
                end
            end
            rready = 1'b1;
            step();
            rready = 1'b0;
            checkBit("rvalid_taken", rvalid, 1'b0);
        end
        checkBit("arready_back", arready, 1'b1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int waits;
        wbuf[0] = v.wdata;
        writeBurst(v.waddr, 0, 1'b0);
        rbuf[0] = v.expData;
        readBurst(v.raddr, 0, -1, waits);
    endtask

    initial begin
        int waits;

        // Single-beat vectors: plain access, ignored low bits, ignored high bits, top word, overwrite.
        vecs[0] = '{waddr: 32'h0000_0010, wdata: 32'hDEAD_BEEF, raddr: 32'h0000_0010, expData: 32'hDEAD_BEEF};
        vecs[1] = '{waddr: 32'h0000_0203, wdata: 32'h1111_2222, raddr: 32'h0000_0200, expData: 32'h1111_2222};
        vecs[2] = '{waddr: 32'h0000_4020, wdata: 32'h3333_4444, raddr: 32'h0000_0020, expData: 32'h3333_4444};
        vecs[3] = '{waddr: 32'h0000_3FFC, wdata: 32'hA5A5_A5A5, raddr: 32'hFFFF_FFFC, expData: 32'hA5A5_A5A5};
        vecs[4] = '{waddr: 32'h0000_0010, wdata: 32'h0000_0000, raddr: 32'h0000_0010, expData: 32'h0000_0000};

        rst     = 1'b1;
        awaddr  = '0;
        awlen   = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wready  = 1'b0;
        araddr  = '0;
        arlen   = '0;
        arvalid = 1'b0;
        rready  = 1'b0;

        // Reset state.
        step();
        step();
        step();
        checkAllZero("reset");
        rst = 1'b0;
        step();
        checkBit("idle_awready", awready, 1'b1);
        checkBit("idle_arready", arready, 1'b1);

        // Table-driven single-beat write/read pairs.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
        end

        // Four-beat write with wready toggling, then read back.
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'(i + 1);
            rbuf[i] = 32'(i + 1);
        end
        writeBurst(32'h100, 3, 1'b1);
        readBurst(32'h100, 3, -1, waits);

        // Same read with rready held low for five cycles on the second beat.
        readBurst(32'h100, 3, 1, waits);

        // Simultaneous write and read requests: write first, read right after.
        wbuf[0] = 32'h600D_0001;
        wbuf[1] = 32'h600D_0002;
        rbuf[0] = 32'h600D_0001;
        rbuf[1] = 32'h600D_0002;
        araddr  = 32'h600;
        arlen   = 8'd1;
        arvalid = 1'b1;
        writeBurst(32'h600, 1, 1'b0);
        readBurst(32'h600, 1, -1, waits);
        checkOutput("ar_pending_wait", 32'(waits), 32'd0);

        // Write burst starting at the top word wraps to word 0.
        wbuf[0] = 32'hAAAA_0001;
        wbuf[1] = 32'hBBBB_0002;
        writeBurst(32'h3FFC, 1, 1'b0);
        rbuf[0] = 32'hBBBB_0002;
        readBurst(32'h0, 0, -1, waits);
        rbuf[0] = 32'hAAAA_0001;
        rbuf[1] = 32'hBBBB_0002;
        readBurst(32'h3FFC, 1, -1, waits);

        // Reset during the third beat of an eight-beat write.
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 32'hC0DE_0000 + 32'(i);
        end
        writeBurst(32'h400, 7, 1'b0);
        checkBit("abort_awready", awready, 1'b1);
        awaddr  = 32'h400;
        awlen   = 8'd7;
        awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        wready  = 1'b1;
        wdata   = 32'hBEEF_0000;
        step();
        wdata   = 32'hBEEF_0001;
        step();
        checkBit("abort_wvalid", wvalid, 1'b1);
        wdata = 32'hBEEF_0002;
        rst   = 1'b1;
        step();
        checkAllZero("abort");
        rst    = 1'b0;
        wready = 1'b0;
        step();
        checkBit("abort_recover", awready, 1'b1);
        rbuf[0] = 32'hBEEF_0000;
        rbuf[1] = 32'hBEEF_0001;
        for (int i = 2; i < 8; i++) begin
            rbuf[i] = 32'hC0DE_0000 + 32'(i);
        end
        readBurst(32'h400, 7, -1, waits);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
